// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store memory access unit.
package mem_access_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // log2 of the access size in bytes; bit 2 only selects signedness for loads
  function automatic logic [1:0] access_size_log2(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

  // true when the low address bits are not a multiple of the access size
  function automatic logic is_misaligned(input logic [2:0] lo_addr, input logic [2:0] funct3);
    logic mis;
    case (access_size_log2(funct3))
      2'b00:   mis = 1'b0;
      2'b01:   mis = lo_addr[0];
      2'b10:   mis = |lo_addr[1:0];
      default: mis = |lo_addr;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Load extension and store byte-merge for the memory access unit.
// The memory returns the doubleword starting at the access address, so
// both paths work on the low lanes only.
module mem_align
  import mem_access_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rd_data,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merge_data
);

  // extend the loaded low bytes to the full register width
  always_comb begin
    load_data = rd_data;
    case (funct3)
      F3_LB:   load_data = {{(XLEN-8){rd_data[7]}}, rd_data[7:0]};
      F3_LH:   load_data = {{(XLEN-16){rd_data[15]}}, rd_data[15:0]};
      F3_LW:   load_data = {{(XLEN-32){rd_data[31]}}, rd_data[31:0]};
      F3_LD:   load_data = rd_data;
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, rd_data[7:0]};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, rd_data[15:0]};
      F3_LWU:  load_data = {{(XLEN-32){1'b0}}, rd_data[31:0]};
      default: load_data = rd_data;
    endcase
  end

  // overlay the low store bytes on the doubleword read back from memory
  always_comb begin
    merge_data = rd_data;
    case (access_size_log2(funct3))
      F3_SB[1:0]: merge_data[7:0]  = wdata[7:0];
      F3_SH[1:0]: merge_data[15:0] = wdata[15:0];
      F3_SW[1:0]: merge_data[31:0] = wdata[31:0];
      F3_SD[1:0]: merge_data       = wdata;
      default:    merge_data       = rd_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-request load/store unit in front of a byte-addressed data memory.
// Optional: define MEM_ACCESS_MISALIGN_CHECK_EN to reject misaligned or
// out-of-range accesses with resp_err instead of issuing them.
//
// state  | meaning
// IDLE   | ready for a request, latches it on accept
// LD     | load read, extended data captured into resp_rdata
// RMW_RD | sub-doubleword store: read old doubleword, merge store bytes
// WR     | single write cycle (full wdata for sd, merged word otherwise)
// RESP   | one-cycle completion pulse, not ready
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int MEM_BYTES = 65536
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_adr,
  output logic [XLEN-1:0] mem_din,
  output logic            mem_mrd,
  output logic            mem_mwr,
  input  logic [XLEN-1:0] mem_dout
);

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic            mrd, mwr;
  logic            req_err, range_err;
  logic [XLEN-1:0] load_ext, merged;

  mem_align #(.XLEN(XLEN)) u_align (
    .funct3     (funct3_q),
    .rd_data    (mem_dout),
    .wdata      (wdata_q),
    .load_data  (load_ext),
    .merge_data (merged)
  );

  // rejection decision for the request currently offered
  always_comb begin
    range_err = ({1'b0, req_addr} + (XLEN+1)'(7)) >= (XLEN+1)'(MEM_BYTES);
    req_err   = (!req_we && req_funct3 == 3'b111) ||
                (CHECK_EN && (is_misaligned(req_addr[2:0], req_funct3) || range_err));
  end

  // next-state, datapath updates and memory strobes
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mrd        = 1'b0;
    mwr        = 1'b0;
    mem_din    = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d   = req_addr;
          we_d     = req_we;
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          err_d    = req_err;
          if (req_err)                                    state_d = RESP;
          else if (!req_we)                               state_d = LD;
          else if (access_size_log2(req_funct3) == 2'b11) state_d = WR;
          else                                            state_d = RMW_RD;
        end
      end
      LD: begin
        mrd     = 1'b1;
        rdata_d = load_ext;
        state_d = RESP;
      end
      RMW_RD: begin
        mrd     = 1'b1;
        data_d  = merged;
        state_d = WR;
      end
      WR: begin
        mwr     = 1'b1;
        mem_din = (access_size_log2(funct3_q) == 2'b11) ? wdata_q : data_q;
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and latched request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // strobes are killed while reset is held so an aborted WR never commits
  always_comb begin
    mem_mrd    = mrd & ~rst;
    mem_mwr    = mwr & ~rst;
    mem_adr    = addr_q;
    resp_rdata = rdata_q;
    resp_err   = resp_valid & err_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a byte-array memory model.
module tb_mem_access_unit;

  localparam int XLEN      = 64;
  localparam int MEM_BYTES = 65536;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_we = 1'b0;
  logic [2:0]      req_funct3 = '0;
  logic [XLEN-1:0] req_addr = '0;
  logic [XLEN-1:0] req_wdata = '0;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic [XLEN-1:0] mem_adr;
  logic [XLEN-1:0] mem_din;
  logic            mem_mrd;
  logic            mem_mwr;
  logic [XLEN-1:0] mem_dout;

  logic [7:0]  mem     [0:MEM_BYTES-1];
  logic [7:0]  ref_mem [0:MEM_BYTES-1];
  logic        mem_init = 1'b0;
  logic [63:0] last_rdata = '0;
  int          checks = 0;
  int          failures = 0;
  int          n_resp_seen = 0;
  int          n_resp_exp = 0;

  mem_access_unit #(.XLEN(XLEN), .MEM_BYTES(MEM_BYTES)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_adr    (mem_adr),
    .mem_din    (mem_din),
    .mem_mrd    (mem_mrd),
    .mem_mwr    (mem_mwr),
    .mem_dout   (mem_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 151) ^ (i >> 7) ^ 8'h5A);
  endfunction

  // attached memory: combinational little-endian read, byte writes on mwr
  always_comb begin
    mem_dout = '0;
    for (int i = 0; i < 8; i++)
      mem_dout[8*i +: 8] = mem[16'(mem_adr[15:0] + 16'(i))];
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= init_byte(i);
    end else if (mem_mwr) begin
      for (int i = 0; i < 8; i++) mem[16'(mem_adr[15:0] + 16'(i))] <= mem_din[8*i +: 8];
    end
  end

  always @(negedge clk) if (resp_valid) n_resp_seen++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_dw(input logic [63:0] a);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = mem[16'(a[15:0] + 16'(i))];
    return v;
  endfunction

  function automatic logic [63:0] ref_dw(input logic [63:0] a);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[16'(a[15:0] + 16'(i))];
    return v;
  endfunction

  function automatic bit model_err(input logic we, input logic [2:0] f3, input logic [63:0] a);
    int n;
    n = 1 << f3[1:0];
    if (!we && f3 == 3'b111) return 1'b1;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    if ((a % 64'(n)) != 0) return 1'b1;
    if (a + 64'd7 >= 64'(MEM_BYTES)) return 1'b1;
`else
    if (n < 0 || a > 64'hFFFF_FFFF_FFFF_FFF0) return 1'b0;
`endif
    return 1'b0;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] a);
    int n;
    logic [63:0] v;
    n = 1 << f3[1:0];
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[16'(a[15:0] + 16'(i))];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // issue one request, follow it to its response and compare against the model
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input bit hold);
    int  lat, n_rd, n_wr, n_both, n_busy, waits, e_lat, e_rd, e_wr, n;
    bit  e_err, got;
    e_err = model_err(we, f3, a);
    n     = 1 << f3[1:0];
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    waits = 0;
    while (!req_ready && waits < 8) begin @(posedge clk); #1; waits++; end
    if (!req_ready) begin
      check("accept_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    lat = 1; n_rd = 0; n_wr = 0; n_both = 0; n_busy = 0; got = 1'b0;
    while (lat <= 8) begin
      n_rd += int'(mem_mrd);
      n_wr += int'(mem_mwr);
      if (mem_mrd && mem_mwr) n_both++;
      if (req_ready) n_busy++;
      if (resp_valid) begin got = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
    if (e_err)                e_lat = 1;
    else if (!we || n == 8)   e_lat = 2;
    else                      e_lat = 3;
    e_rd = (e_err || (we && n == 8)) ? 0 : 1;
    e_wr = (!e_err && we) ? 1 : 0;
    if (!e_err && we)
      for (int i = 0; i < n; i++) ref_mem[16'(a[15:0] + 16'(i))] = wd[8*i +: 8];
    if (!e_err && !we) last_rdata = model_load(f3, a);
    n_resp_exp++;
    check("resp_seen", 64'(got), 64'd1);
    check("latency", 64'(lat), 64'(e_lat));
    check("resp_err", 64'(resp_err), 64'(e_err));
    check("resp_rdata", resp_rdata, last_rdata);
    check("mrd_cycles", 64'(n_rd), 64'(e_rd));
    check("mwr_cycles", 64'(n_wr), 64'(e_wr));
    check("mrd_mwr_overlap", 64'(n_both), 64'd0);
    check("ready_while_busy", 64'(n_busy), 64'd0);
    check("mem_window", dut_dw(a), ref_dw(a));
    check("mem_edges", {48'd0, mem[16'(a[15:0] + 16'd8)], mem[16'(a[15:0] - 16'd1)]},
          {48'd0, ref_mem[16'(a[15:0] + 16'd8)], ref_mem[16'(a[15:0] - 16'd1)]});
  endtask

  initial begin
    int          mism;
    logic [63:0] a, wd;
    logic [2:0]  f3;
    logic        we;

    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
    rst = 1'b1; mem_init = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_init = 1'b0;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);
    check("rst_strobes", {62'd0, mem_mrd, mem_mwr}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed sequence around address 2000
    run_req(1'b1, 3'b011, 64'd2000, 64'h1122334455667788, 1'b0);
    check("sd_content", dut_dw(64'd2000), 64'h1122334455667788);
    run_req(1'b0, 3'b000, 64'd2000, 64'd0, 1'b0);
    check("lb_value", resp_rdata, 64'hFFFF_FFFF_FFFF_FF88);
    run_req(1'b0, 3'b100, 64'd2000, 64'd0, 1'b0);
    check("lbu_value", resp_rdata, 64'h88);
    run_req(1'b1, 3'b000, 64'd2001, 64'hAB, 1'b0);
    check("sb_content", dut_dw(64'd2000), 64'h1122334455667788 & ~64'hFF00 | 64'hAB00);
    run_req(1'b0, 3'b010, 64'd2002, 64'd0, 1'b0);
`ifndef MEM_ACCESS_MISALIGN_CHECK_EN
    check("lw_unaligned", resp_rdata, 64'h0000_0000_3344_5566);
`endif
    run_req(1'b0, 3'b111, 64'd2000, 64'd0, 1'b0);

    // reset while the write of an sd is pending
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b011;
    req_addr = 64'd2008; req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk); #1;
    check("pre_accept_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("wr_cycle_mwr", 64'(mem_mwr), 64'd1);
    rst = 1'b1;
    #1 check("rst_kills_mwr", 64'(mem_mwr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_rdata = '0;
    check("abort_no_resp", 64'(resp_valid), 64'd0);
    check("abort_rdata", resp_rdata, 64'd0);
    @(posedge clk); #1;
    check("abort_no_resp2", 64'(resp_valid), 64'd0);
    check("abort_ready", 64'(req_ready), 64'd1);
    check("abort_mem", dut_dw(64'd2008), ref_dw(64'd2008));
    run_req(1'b0, 3'b011, 64'd2000, 64'd0, 1'b0);

    // back-to-back requests with req_valid held high
    for (int k = 0; k < 8; k++) begin
      a  = 64'($urandom_range(16, 8000));
      wd = {$urandom, $urandom};
      f3 = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      run_req(we, f3, a, wd, 1'b1);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;

    // randomized traffic, half aligned to the doubleword, in a small window
    for (int k = 0; k < 60; k++) begin
      a  = 64'($urandom_range(3000, 3100));
      if ($urandom_range(0, 1) == 1) a = a & ~64'd7;
      wd = {$urandom, $urandom};
      f3 = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      run_req(we, f3, a, wd, 1'b0);
    end

    // range boundary near the top of memory
    run_req(1'b0, 3'b011, 64'(MEM_BYTES - 8), 64'd0, 1'b0);
    run_req(1'b0, 3'b000, 64'(MEM_BYTES - 4), 64'd0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("resp_pulse_count", 64'(n_resp_seen), 64'(n_resp_exp));
    mism = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("mem_final", 64'(mism), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
